// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: mul/div opcode, decoder control word, mul/div FSM states
package cpu_pkg;

    // RV32M operation, encoded exactly as the instruction's funct3 field
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } t_muldiv_op;

    // Decoder control fields routing an instruction to the mul/div unit
    typedef struct packed {
        logic       sel_muldiv;
        t_muldiv_op muldiv_op;
    } t_ctrl;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } t_muldiv_state;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input t_muldiv_op op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic op_b_signed(input t_muldiv_op op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 multiply or divide iteration
// Ports: is_div selects divide; hi/lo form the 2*XLEN working register
// (multiply: product-high / remaining multiplier bits; divide: partial
// remainder / dividend-then-quotient bits); b is the operand magnitude;
// hi_next/lo_next are the register contents after this step.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then
        // shift the whole register right carrying the sum's overflow in.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        // Divide: bring the next dividend bit into the partial remainder and
        // keep the subtraction only if the divisor fits.
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b};
        fits    = (shifted >= {1'b0, b});
        if (is_div) begin
            hi_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], fits};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, UNROLL bits per cycle
// Ports: clk, rst (sync, active-high); request in_valid/in_ready with
// in_op/in_a/in_b/in_rd; flush kills any operation; result
// out_valid/out_ready with registered out_result/out_rd.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  t_muldiv_op      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);

    localparam int ITER  = XLEN / UNROLL;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    t_muldiv_state   state, state_next;
    t_muldiv_op      op_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic            neg_main_q;   // product / quotient must be negated
    logic            neg_rem_q;    // remainder takes the dividend's sign
    logic [CNT_W-1:0] cnt_q;

    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_by_zero, div_ovf;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, result_d;

    logic [XLEN-1:0] hi_c [UNROLL+1];
    logic [XLEN-1:0] lo_c [UNROLL+1];

    assign in_ready  = (state == MD_IDLE);
    assign out_valid = (state == MD_DONE);
    assign accept    = (state == MD_IDLE) && in_valid && !flush;

    always_comb begin
        a_neg       = op_a_signed(in_op) && in_a[XLEN-1];
        b_neg       = op_b_signed(in_op) && in_b[XLEN-1];
        abs_a       = a_neg ? -in_a : in_a;
        abs_b       = b_neg ? -in_b : in_b;
        div_by_zero = in_op[2] && (in_b == '0);
        div_ovf     = ((in_op == MD_DIV) || (in_op == MD_REM))
                      && (in_a == MOST_NEG) && (in_b == '1);
    end

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div  (op_q[2]),
            .hi      (hi_c[g]),
            .lo      (lo_c[g]),
            .b       (b_q),
            .hi_next (hi_c[g+1]),
            .lo_next (lo_c[g+1])
        );
    end

    // Sign correction and result selection, registered on the final CALC cycle
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_main_q ? -prod : prod;
        quo_fix  = neg_main_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q  ? -hi_q : hi_q;
        if (op_q[2]) begin
            result_d = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == MD_MUL) begin
            result_d = prod_fix[XLEN-1:0];
        end else begin
            result_d = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (in_valid)        state_next = MD_CALC;
            MD_CALC: if (cnt_q == '0)     state_next = MD_DONE;
            MD_DONE: if (out_ready)       state_next = MD_IDLE;
            default:                      state_next = MD_IDLE;
        endcase
        if (flush) begin
            state_next = MD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= MD_MUL;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (accept) begin
            op_q       <= in_op;
            out_rd     <= in_rd;
            b_q        <= abs_b;
            hi_q       <= '0;
            lo_q       <= abs_a;
            neg_main_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            cnt_q      <= CNT_W'(ITER);
            // Fast-path cases preload the final quotient/remainder and skip
            // the iterations, spending only the single finalisation cycle.
            if (div_by_zero) begin
                hi_q       <= in_a;
                lo_q       <= '1;
                neg_main_q <= 1'b0;
                neg_rem_q  <= 1'b0;
                cnt_q      <= '0;
            end else if (div_ovf) begin
                hi_q       <= '0;
                lo_q       <= in_a;
                neg_main_q <= 1'b0;
                neg_rem_q  <= 1'b0;
                cnt_q      <= '0;
            end
        end else if ((state == MD_CALC) && !flush) begin
            if (cnt_q != '0) begin
                hi_q  <= hi_c[UNROLL];
                lo_q  <= lo_c[UNROLL];
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                out_result <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import cpu_pkg::*;

    parameter int XLEN   = 32;
    parameter int UNROLL = 1;
    localparam int LAT     = XLEN / UNROLL + 1;
    localparam int TIMEOUT = 4 * LAT + 20;
    localparam logic [XLEN-1:0] MN = {1'b1, {(XLEN-1){1'b0}}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    t_muldiv_op      in_op = MD_MUL;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;
    logic [4:0]      in_rd = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;

    int checks = 0;
    int passes = 0;

    muldiv_unit #(.XLEN(XLEN), .UNROLL(UNROLL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain 64-bit integer arithmetic
    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [XLEN-1:0] r;
        sa = {{(64-XLEN){a[XLEN-1]}}, a};
        sb = {{(64-XLEN){b[XLEN-1]}}, b};
        ua = {{(64-XLEN){1'b0}}, a};
        ub = {{(64-XLEN){1'b0}}, b};
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[XLEN-1:0]; end
            3'd1: begin p = sa * sb; r = p[2*XLEN-1:XLEN]; end
            3'd2: begin p = sa * ub; r = p[2*XLEN-1:XLEN]; end
            3'd3: begin p = ua * ub; r = p[2*XLEN-1:XLEN]; end
            3'd4: if (b == '0) r = '1; else begin p = sa / sb; r = p[XLEN-1:0]; end
            3'd5: if (b == '0) r = '1; else begin p = ua / ub; r = p[XLEN-1:0]; end
            3'd6: if (b == '0) r = a;  else begin p = sa % sb; r = p[XLEN-1:0]; end
            default: if (b == '0) r = a; else begin p = ua % ub; r = p[XLEN-1:0]; end
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        if (op[2] && b == '0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MN && b == '1) return 1;
        return LAT;
    endfunction

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return MN;
            3: return XLEN'(1);
            4: return MN - XLEN'(1);
            default: return XLEN'($urandom);
        endcase
    endfunction

    // Issue one request, wait (bounded) for the result, then consume it.
    // lat = edges from the accepting edge until out_valid is first seen.
    task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] rd,
                          output logic [XLEN-1:0] res, output logic [4:0] rdo,
                          output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = t_muldiv_op'(op);
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        res = out_result;
        rdo = out_rd;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_result !== '0) $display("FAIL reset_out_result got %h want 0", out_result); else passes++;
        checks++; if (out_rd !== 5'd0) $display("FAIL reset_out_rd got %0d want 0", out_rd); else passes++;
    endtask

    task automatic test_mul();
        logic [2:0]      ops [4];
        logic [XLEN-1:0] as  [4];
        logic [XLEN-1:0] bs  [4];
        logic [XLEN-1:0] res, exp_res;
        logic [4:0]      rdo;
        int              lat;
        ops[0] = 3'd0; as[0] = XLEN'(7); bs[0] = XLEN'(-3);
        ops[1] = 3'd1; as[1] = MN;       bs[1] = MN;
        ops[2] = 3'd3; as[2] = '1;       bs[2] = '1;
        ops[3] = 3'd2; as[3] = '1;       bs[3] = '1;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 1), res, rdo, lat);
            exp_res = ref_result(ops[i], as[i], bs[i]);
            checks++; if (res !== exp_res) $display("FAIL mul_result[%0d] got %h want %h", i, res, exp_res); else passes++;
            checks++; if (rdo !== 5'(i + 1)) $display("FAIL mul_rd[%0d] got %0d want %0d", i, rdo, i + 1); else passes++;
            checks++; if (lat != LAT) $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, LAT); else passes++;
        end
    endtask

    task automatic test_div();
        logic [2:0]      ops [4];
        logic [XLEN-1:0] as  [4];
        logic [XLEN-1:0] bs  [4];
        logic [XLEN-1:0] res, exp_res;
        logic [4:0]      rdo;
        int              lat;
        ops[0] = 3'd4; as[0] = XLEN'(-7); bs[0] = XLEN'(2);
        ops[1] = 3'd6; as[1] = XLEN'(-7); bs[1] = XLEN'(2);
        ops[2] = 3'd5; as[2] = XLEN'(100); bs[2] = XLEN'(7);
        ops[3] = 3'd7; as[3] = XLEN'(100); bs[3] = XLEN'(7);
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 10), res, rdo, lat);
            exp_res = ref_result(ops[i], as[i], bs[i]);
            checks++; if (res !== exp_res) $display("FAIL div_result[%0d] got %h want %h", i, res, exp_res); else passes++;
            checks++; if (rdo !== 5'(i + 10)) $display("FAIL div_rd[%0d] got %0d want %0d", i, rdo, i + 10); else passes++;
            checks++; if (lat != LAT) $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, LAT); else passes++;
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]      ops [6];
        logic [XLEN-1:0] as  [6];
        logic [XLEN-1:0] bs  [6];
        logic [XLEN-1:0] res, exp_res;
        logic [4:0]      rdo;
        int              lat;
        ops[0] = 3'd4; as[0] = XLEN'(5); bs[0] = '0;
        ops[1] = 3'd6; as[1] = XLEN'(5); bs[1] = '0;
        ops[2] = 3'd4; as[2] = MN;       bs[2] = '1;
        ops[3] = 3'd6; as[3] = MN;       bs[3] = '1;
        ops[4] = 3'd5; as[4] = MN;       bs[4] = '0;
        ops[5] = 3'd7; as[5] = XLEN'(-9); bs[5] = '0;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 20), res, rdo, lat);
            exp_res = ref_result(ops[i], as[i], bs[i]);
            checks++; if (res !== exp_res) $display("FAIL fast_result[%0d] got %h want %h", i, res, exp_res); else passes++;
            checks++; if (rdo !== 5'(i + 20)) $display("FAIL fast_rd[%0d] got %0d want %0d", i, rdo, i + 20); else passes++;
            checks++; if (lat != 1) $display("FAIL fast_latency[%0d] got %0d want 1", i, lat); else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] a, b, exp_res, res;
        logic [4:0]      rdo;
        int              waited;
        a = pick_operand();
        b = pick_operand();
        exp_res = ref_result(3'd0, a, b);
        @(negedge clk);
        in_valid = 1'b1; in_op = MD_MUL; in_a = a; in_b = b; in_rd = 5'd17;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (!out_valid) $display("FAIL bp_wait_valid got timeout after %0d want out_valid", waited); else passes++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (!(out_valid === 1'b1 && out_result === exp_res && out_rd === 5'd17 && in_ready === 1'b0))
                $display("FAIL bp_hold[%0d] got valid=%b res=%h rd=%0d ready=%b want 1/%h/17/0",
                         i, out_valid, out_result, out_rd, in_ready, exp_res);
            else passes++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (!(in_ready === 1'b1 && out_valid === 1'b0))
            $display("FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
        else passes++;
        run_op(3'd5, XLEN'(1000), XLEN'(9), 5'd3, res, rdo, waited);
        checks++; if (res !== XLEN'(111) || rdo !== 5'd3) $display("FAIL bp_next got %h/%0d want %h/3", res, rdo, XLEN'(111)); else passes++;
    endtask

    task automatic test_flush_reset();
        logic [XLEN-1:0] res;
        logic [4:0]      rdo;
        int              lat, seen;
        // flush five cycles into CALC
        @(negedge clk);
        in_valid = 1'b1; in_op = MD_DIVU; in_a = XLEN'(12345); in_b = XLEN'(7); in_rd = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL flush_idle got ready=%b valid=%b want 1/0", in_ready, out_valid); else passes++;
        seen = 0;
        repeat (LAT + 5) begin @(negedge clk); if (out_valid) seen++; end
        checks++; if (seen != 0) $display("FAIL flush_no_valid got %0d valid cycles want 0", seen); else passes++;
        // flush beats a simultaneous request
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = MD_MUL; in_a = XLEN'(2); in_b = XLEN'(2);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL flush_priority got ready=%b want 1", in_ready); else passes++;
        seen = 0;
        repeat (LAT + 2) begin @(negedge clk); if (out_valid) seen++; end
        checks++; if (seen != 0) $display("FAIL flush_priority_valid got %0d valid cycles want 0", seen); else passes++;
        // reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1; in_op = MD_MULH; in_a = XLEN'(-5); in_b = XLEN'(77); in_rd = 5'd30;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_rd !== 5'd0)
            $display("FAIL reset_mid got ready=%b valid=%b res=%h rd=%0d want 1/0/0/0", in_ready, out_valid, out_result, out_rd);
        else passes++;
        seen = 0;
        repeat (LAT + 5) begin @(negedge clk); if (out_valid) seen++; end
        checks++; if (seen != 0) $display("FAIL reset_no_valid got %0d valid cycles want 0", seen); else passes++;
        run_op(3'd0, XLEN'(3), XLEN'(4), 5'd21, res, rdo, lat);
        checks++; if (res !== XLEN'(12)) $display("FAIL after_abort_result got %h want %h", res, XLEN'(12)); else passes++;
        checks++; if (rdo !== 5'd21) $display("FAIL after_abort_rd got %0d want 21", rdo); else passes++;
        checks++; if (lat != LAT) $display("FAIL after_abort_latency got %0d want %0d", lat, LAT); else passes++;
    endtask

    task automatic test_random();
        logic [2:0]      op;
        logic [XLEN-1:0] a, b, res, exp_res;
        logic [4:0]      rd, rdo;
        int              lat, exp_lat;
        for (int i = 0; i < 1000; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            exp_res = ref_result(op, a, b);
            exp_lat = ref_latency(op, a, b);
            run_op(op, a, b, rd, res, rdo, lat);
            checks++; if (res !== exp_res) $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, exp_res); else passes++;
            checks++; if (rdo !== rd) $display("FAIL rand_rd[%0d] got %0d want %0d", i, rdo, rd); else passes++;
            checks++; if (lat != exp_lat) $display("FAIL rand_latency[%0d] op=%0d got %0d want %0d", i, op, lat, exp_lat); else passes++;
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_backpressure();
        test_flush_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
